// File: rtl/lbp_pkg.sv
// Shared constants, FSM encoding and debug view for the LBP histogram block.
package lbp_pkg;
   localparam int IMG_W  = 128;
   localparam int IMG_H  = 128;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int LBP_AW = 14;
   localparam int LBP_DW = 8;
   localparam int NBIN   = 256;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      DRAIN   = 2'd1,
      READOUT = 2'd2,
      DONE    = 2'd3
   } lbp_state_t;

   typedef struct packed {
      lbp_state_t          state;
      logic [LBP_AW-1:0]   last_addr;
   } lbp_dbg_t;
endpackage

// File: rtl/hist_bank.sv
// 256-entry bin counter storage: registered read port, write port, async clear.
// A read and a write to the same address in one cycle returns the old value.
module hist_bank
   import lbp_pkg::*;
#(
   parameter int CW = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [LBP_DW-1:0] rd_addr,
   output logic [CW-1:0]     rd_data,
   input  logic              wr_en,
   input  logic [LBP_DW-1:0] wr_addr,
   input  logic [CW-1:0]     wr_data
);

   logic [CW-1:0] mem [NBIN];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NBIN; i++) mem[i] <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) mem[wr_addr] <= wr_data;
         if (rd_en) rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lbp_hist.sv
// Snoops the LBP write bus into a 256-bin histogram, then streams and clears
// the bins over a valid/ready port once the engine signals frame completion.
module lbp_hist
   import lbp_pkg::*;
#(
   parameter int CW   = 15,
   parameter int NPIX = lbp_pkg::NPIX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lbp_valid,
   input  logic [LBP_AW-1:0] lbp_addr,
   input  logic [LBP_DW-1:0] lbp_data,
   input  logic              finish,
   output logic              hist_valid,
   input  logic              hist_ready,
   output logic [LBP_DW-1:0] hist_bin,
   output logic [CW-1:0]     hist_count,
   output logic              hist_done,
   output logic              tot_ok,
   output logic              ovf,
   output lbp_dbg_t          dbg
);

   // Readout handshake: a bin transfers on a cycle where hist_valid and
   // hist_ready are both high; while hist_valid is high and hist_ready low,
   // hist_bin and hist_count hold steady. hist_valid never drops before transfer.

   lbp_state_t state, state_nxt;
   logic              drain_cnt;
   logic              armed;
   logic [14:0]       tot;
   logic [LBP_AW-1:0] last_addr;

   logic              v1;
   logic [LBP_DW-1:0] c1;
   logic              wv;
   logic [LBP_DW-1:0] wcode;
   logic [CW-1:0]     wval;

   logic [LBP_DW-1:0] bin;
   logic              hv;
   logic              ovf_r;

   logic              rd_en, wr_en;
   logic [LBP_DW-1:0] rd_addr, wr_addr;
   logic [CW-1:0]     rd_data, wr_data;

   logic              accept, illegal, hs, last_bin;
   logic [CW-1:0]     base, upd;
   logic              sat;

   assign accept   = (state == ACCUM) && lbp_valid;
   assign illegal  = (state != ACCUM) && lbp_valid;
   assign hs       = hv && hist_ready;
   assign last_bin = (bin == LBP_DW'(NBIN - 1));

   // The bank returns old data when S1 wrote the same bin last cycle.
   assign base = (wv && (wcode == c1)) ? wval : rd_data;
   assign sat  = &base;
   assign upd  = sat ? base : base + CW'(1);

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = lbp_data;
      wr_en   = 1'b0;
      wr_addr = c1;
      wr_data = upd;
      if (accept) rd_en = 1'b1;
      if (v1) wr_en = 1'b1;
      if (state == DRAIN && drain_cnt) begin
         rd_en   = 1'b1;
         rd_addr = '0;
      end
      // Clear the accepted bin and prefetch the next so there is no bubble.
      if (hs) begin
         wr_en   = 1'b1;
         wr_addr = bin;
         wr_data = '0;
         rd_en   = 1'b1;
         rd_addr = bin + LBP_DW'(1);
      end
   end

   hist_bank #(.CW(CW)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (finish && armed) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt) state_nxt = READOUT;
         READOUT: if (hs && last_bin) state_nxt = DONE;
         DONE:    state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ACCUM;
         drain_cnt <= 1'b0;
         armed     <= 1'b1;
         tot       <= '0;
         last_addr <= '0;
         v1        <= 1'b0;
         c1        <= '0;
         wv        <= 1'b0;
         wcode     <= '0;
         wval      <= '0;
         bin       <= '0;
         hv        <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         // A finish level still high after DONE must drop before it counts again.
         if (state == DONE) armed <= 1'b0;
         else if (!finish) armed <= 1'b1;

         if (state == DONE) tot <= '0;
         else if (accept && !(&tot)) tot <= tot + 15'd1;
         if (accept) last_addr <= lbp_addr;

         v1 <= accept;
         if (accept) c1 <= lbp_data;
         wv    <= v1;
         wcode <= c1;
         wval  <= upd;

         if (state == DRAIN && drain_cnt) hv <= 1'b1;
         else if (hs && last_bin) hv <= 1'b0;
         if (hs) bin <= bin + LBP_DW'(1);

         if (illegal || (v1 && sat)) ovf_r <= 1'b1;
      end
   end

   assign hist_valid = hv;
   assign hist_bin   = bin;
   assign hist_count = hv ? rd_data : '0;
   assign hist_done  = (state == DONE);
   assign tot_ok     = (state == DONE) && (tot == 15'(NPIX));
   assign ovf        = ovf_r;
   assign dbg        = '{state: state, last_addr: last_addr};

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP engine's output stream on a 128x128 frame.
- Snoops the `lbp_valid`/`lbp_addr`/`lbp_data` write bus in parallel with the result memory, and builds a 256-bin histogram of LBP codes.
- When the engine raises `finish`, streams the 256 bin counts out over a valid/ready port, clearing each bin as it is read, so the block is ready for the next frame.

Parameters:
- CW, 15, bin counter width; 2^CW-1 ≥ 16384 pixels, and counters saturate at 2^CW-1.
- NPIX, 16384, pixels per frame; used for the `tot_ok` check.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- lbp_valid  in  1  LBP write strobe; one code per cycle when high
- lbp_addr  in  14  LBP pixel address; counted only for the `tot` statistic
- lbp_data  in  8  LBP code = histogram bin index
- finish  in  1  LBP frame-complete level/pulse
- hist_valid  out  1  `hist_bin`/`hist_count` valid
- hist_ready  in  1  sink accepts the current bin
- hist_bin  out  8  bin index 0..255
- hist_count  out  CW  count for `hist_bin`
- hist_done  out  1  one-cycle pulse after bin 255 is accepted
- tot_ok  out  1  total accepted samples == NPIX, valid with `hist_done`
- ovf  out  1  sticky: sample arrived outside ACCUM, or a bin saturated

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - FSM=ACCUM, pipeline empty, `tot`=0.
  - Bank contents cleared (flop array with async clear).
- Storage sub-module `hist_bank`:
  - 256xCW, one synchronous read port (1-cycle latency), one write port.
  - A write and a read to the same address in one cycle returns the OLD data; the parent forwards.
- ACCUM pipeline:
  - S0: on `lbp_valid`, register code c0, issue bank read at c0, `tot`++ (saturating at 2^15-1).
  - S1: new = (c1 == code written by S1 in the previous cycle) ? forwarded value : bank rdata; write c1 ← new+1, saturating at 2^CW-1, which sets `ovf`.
  - Back-to-back identical codes must count exactly (e.g. 3x code 0x7F gives 3).
  - Throughput is 1 sample/cycle, with no backpressure on the LBP side.
- FSM transitions:
  - ACCUM → DRAIN when `finish`=1 is sampled.
  - DRAIN: 2 cycles, letting S0/S1 retire, then → READOUT. `lbp_valid` in DRAIN is dropped and sets `ovf`.
  - READOUT:
    - Issue read for bin 0; the next cycle assert `hist_valid` with `hist_bin`=0.
    - Outputs hold stable while `hist_ready`=0.
    - On handshake (`hist_valid` & `hist_ready`): write bin ← 0 and issue the read of bin+1.
    - The next bin's data must be presentable the cycle after acceptance (no bubble), via prefetch.
    - After bin 255 is accepted → DONE.
    - `lbp_valid` in READOUT is dropped and sets `ovf`.
  - DONE (1 cycle): `hist_done`=1, `tot_ok` = (`tot`==NPIX); clear `tot`; → ACCUM, waiting for `finish` to fall.
  - `finish` still high in ACCUM is ignored until it has been seen low once (edge-qualified).
- `ovf` clears only on reset.
- Reset mid-READOUT: everything aborts; the bank is cleared; no `hist_done`.

Decomposition:
- Shared package `lbp_pkg`:
  - IMG_W=128, IMG_H=128, NPIX=16384, LBP_AW=14, LBP_DW=8, NBIN=256.
  - FSM state enum {ACCUM, DRAIN, READOUT, DONE}.
- One sub-module: `hist_bank` (register array plus read/write ports, async clear).

Test Plan:
- Full frame:
  - Stimulus: golden LBP stream of 16384 codes, 1/cycle, then `finish`.
  - Expected: 256 bins match the reference histogram; sum=16384; `tot_ok`=1; `hist_done` exactly one pulse, one cycle after the bin-255 handshake.
- Hazard:
  - Stimulus: codes 0x7F,0x7F,0x7F,0x00,0x7F back-to-back.
  - Expected: bin 0x7F=4, bin 0x00=1, all other bins 0.
- Backpressure:
  - Stimulus: `hist_ready` toggled randomly at 50%.
  - Expected: no bin skipped or duplicated; `hist_bin`/`hist_count` stable while `hist_valid` & !`hist_ready`; bins arrive 0..255 in order.
- Read-and-clear:
  - Stimulus: frame A of all code 0x05, readout, then frame B of all code 0xFF.
  - Expected: frame B readout has bin 0x05=0 and bin 0xFF=16384.
- Illegal timing:
  - Stimulus: `lbp_valid` pulsed during READOUT; 100 samples, then `finish`.
  - Expected: `ovf`=1 and stays 1; sample not counted; `tot_ok`=0.
- Async reset:
  - Stimulus: reset asserted mid-READOUT at bin 37.
  - Expected: outputs 0 immediately; after release, a new frame of 10 samples of code 0x22 reads back 10 with all other bins 0.
